// File: rtl/tick_prescaler_pkg.sv
// Shared definitions for the tick prescaler and the counter chain it drives.
package tick_prescaler_pkg;

  // Prescaler controller states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

  // Width of the burst/tick counter, shared with the 4-digit down counter chain.
  localparam int unsigned BURST_W = 4;

endpackage : tick_prescaler_pkg

// File: rtl/reload_down_counter.sv
// Down counter with synchronous load, count enable and zero flag.
// Counting stops at zero; it never wraps.
module reload_down_counter
  import tick_prescaler_pkg::*;
#(
  parameter int unsigned W = BURST_W
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  // Load has priority over decrement; decrement is blocked at zero.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Zero flag for the controller.
  always_comb begin
    zero = (count == '0);
  end

endmodule : reload_down_counter

// File: rtl/tick_prescaler.sv
// Programmable tick generator: divides the clock by div+1 and emits
// single-cycle enable pulses, free-running or as a counted burst.
module tick_prescaler
  import tick_prescaler_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic               clock,
  input  logic               reset_,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
  input  logic [W-1:0]       div,
  input  logic [BURST_W-1:0] burst,
  output logic               ei,
  output logic               busy,
  output logic               done
);

  state_t state_q, state_d;

  logic [W-1:0]       div_r;
  logic [W-1:0]       pre;
  logic               pre_zero;
  logic [BURST_W-1:0] rem;
  logic               rem_zero;

  logic               capture;
  logic               step;
  logic               tick;
  logic               last;
  logic               pre_load;
  logic [W-1:0]       pre_load_val;
  logic               pre_en;

  // Step and tick qualification.
  // The edge that leaves HOLD (hold low, no stop) also advances the prescaler,
  // so a hold of k cycles delays the next tick by exactly k cycles.
  always_comb begin
    capture      = (state_q == IDLE) && start && !stop;
    step         = ((state_q == RUN) || (state_q == HOLD)) && !stop && !hold;
    tick         = step && pre_zero;
    last         = tick && (rem == BURST_W'(1));
    pre_load     = capture || tick;
    pre_load_val = capture ? div : div_r;
    pre_en       = step && !pre_zero;
  end

  // Prescale counter: reloads on capture and on every tick.
  reload_down_counter #(
    .W (W)
  ) u_pre (
    .clock    (clock),
    .reset_   (reset_),
    .load     (pre_load),
    .load_val (pre_load_val),
    .en       (pre_en),
    .count    (pre),
    .zero     (pre_zero)
  );

  // Burst remaining counter: loaded on capture, decremented per tick.
  reload_down_counter #(
    .W (BURST_W)
  ) u_rem (
    .clock    (clock),
    .reset_   (reset_),
    .load     (capture),
    .load_val (burst),
    .en       (tick),
    .count    (rem),
    .zero     (rem_zero)
  );

  // Next-state logic; stop beats hold beats tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (hold) begin
          state_d = HOLD;
        end else if (last) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!hold) begin
          state_d = last ? IDLE : RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Captured divisor, sampled only when a run is accepted.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      div_r <= '0;
    end else if (capture) begin
      div_r <= div;
    end
  end

  // Registered outputs; busy tracks the state being entered.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      ei   <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      ei   <= tick;
      done <= last;
      busy <= (state_d != IDLE);
    end
  end

  // A burst count of zero means free-running; the zero flag is kept for the counter chain.
  logic unused_rem_zero;
  always_comb begin
    unused_rem_zero = rem_zero;
  end

endmodule : tick_prescaler

// File: doc/tick_prescaler.md
# tick_prescaler

Programmable tick generator driving the `ei` enable input of the 4-digit base-2 down counter chain. It divides the system clock by a loaded divisor and emits single-cycle enable pulses, either free-running or as a counted burst. It supports start/stop/hold control and signals completion of a burst.

## Interface
Parameters:
- `W`, default 8, width of the divisor.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset_`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled request; loads `div` and `burst`, begins counting.
- `stop`  in  1  aborts the current run.
- `hold`  in  1  freezes the prescaler while high.
- `div`  in  W  divisor minus one; tick period is `div+1` clocks.
- `burst`  in  4  number of ticks to emit; 0 means free-running.
- `ei`  out  1  enable pulse to the counter chain, registered.
- `busy`  out  1  high in RUN or HOLD.
- `done`  out  1  one-cycle pulse coinciding with the last tick of a burst.

One clock; reset is asynchronous and active-low.

## Operation
- FSM states: IDLE, RUN, HOLD. Reset state is IDLE.
- Reset values: `ei`=0, `busy`=0, `done`=0, prescale count=0, burst remaining=0, captured divisor=0.
- IDLE:
  - On an edge with `start`=1 and `stop`=0: capture `div` into `div_r`, capture `burst` into `rem`, set `pre`=`div`, go to RUN.
- RUN, on each edge:
  - If `stop`=1: go to IDLE with `ei`<=0 and no `done`.
  - Else if `hold`=1: go to HOLD with `ei`<=0 and `pre` unchanged.
  - Else if `pre`==0: set `ei`<=1 and `pre`<=`div_r`.
    - If `rem`==1: `done`<=1, `rem`<=0, go to IDLE.
    - If `rem`>1: `rem`<=`rem`-1.
    - If `rem`==0 (free-running): unchanged.
  - Else: `pre`<=`pre`-1, `ei`<=0.
- HOLD:
  - `stop`=1 → IDLE.
  - `hold`=0 → RUN.
  - Otherwise stay. `ei`=0 throughout; `pre` and `rem` are frozen.
- `start` while RUN or HOLD is ignored. `div` and `burst` are not re-sampled.
- Priority: `stop` > `hold` > tick.
  - `start` and `stop` on the same IDLE edge: stay IDLE.
  - `hold` in IDLE: ignored.
- Arithmetic: `pre` is W bits, `rem` is 4 bits. Neither ever wraps: reload happens at 0, and `rem` is never decremented from 0.
- `div`=0: `ei` stays high every cycle in RUN. A burst of N gives N consecutive high cycles.

## Timing
- `start` sampled at edge E0. First `ei` goes high after edge E(div+1), then every `div+1` edges.
- `ei`, `done` and `busy` are all registered and change only on edges or asynchronous reset.
- `busy` rises the cycle after E0. It falls on the same edge that raises the final `ei`/`done`, or on a `stop`.
- `done` is high for exactly one cycle, coincident with the final `ei`.
- Restart: a `start` on the edge after `done` is accepted, giving a gap of 1 cycle minimum.
- Reset mid-run: all outputs drop immediately (asynchronously) and the FSM is in IDLE; no `done`.
- A HOLD of k cycles stretches the current tick interval by exactly k cycles.

## Structure
- Shared package: state encoding localparams (IDLE=2'b00, RUN=2'b01, HOLD=2'b10) and the burst width constant (4). The tick counter and the 4-digit down counter share the burst width.
- Natural sub-module: `reload_down_counter`, a W-bit down counter with synchronous load, enable and zero flag. It is used for `pre`; `rem` is a second instance with width 4.
- Top: FSM plus output registers.

## Test plan
- W=8, `div`=3, `burst`=2, `start` pulse: `ei` high after E4 and E8; `done` high with the second `ei`; `busy` low after E8.
- `div`=0, `burst`=3: `ei` high for 3 consecutive cycles after E1..E3; `done` on the third.
- `div`=2, `burst`=0, run 20 cycles, then `stop`: `ei` every 3rd cycle, never `done`; `stop` suppresses a tick due on the same edge.
- `div`=4, `burst`=1, `hold` high for 5 cycles mid-interval: the single `ei` arrives 5 cycles late; `ei`=0 during HOLD; `start` pulsed during HOLD is ignored.
- `reset_` asserted asynchronously between edges during RUN with `rem`=3: outputs drop immediately. After release, IDLE; no `ei` until a new `start`.
- `start` and `stop` high together in IDLE: stays IDLE, `busy`=0. `div` changed while RUN has no effect on the period.
